// File: rtl/serial_sub_using_ha.sv
// ---------------------------------------------------------------------------
// serial_sub_using_ha
//   Bit-serial WIDTH-bit unsigned subtractor computing diff = a - b. It
//   processes one bit per clock, LSB first. Each bit goes through a
//   full-subtractor cell built from four half-adder instances and two
//   inverters. A start/busy/done handshake controls an operation:
//   IDLE -> SHIFT (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
//
// Ports
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous, active-low reset
//   start       in   1      request, sampled only while idle
//   a           in   WIDTH  minuend, captured when start is accepted
//   b           in   WIDTH  subtrahend, captured when start is accepted
//   busy        out  1      high while bits are being shifted
//   done        out  1      one-cycle pulse, diff/borrow_out just updated
//   diff        out  WIDTH  last completed result, (a-b) mod 2^WIDTH
//   borrow_out  out  1      final borrow, 1 iff a < b (unsigned)
//
// The file also holds the half-adder primitive used by the bit cell.
// ---------------------------------------------------------------------------

module ha (
    input  logic in_a,
    input  logic in_b,
    output logic sum,
    output logic carry
);
    assign sum   = in_a ^ in_b;
    assign carry = in_a & in_b;
endmodule

module serial_sub_using_ha #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic             bor;
    logic [CW-1:0]    cnt;

    // Bit-cell nets
    logic x;
    logic d;
    logic not_a;
    logic not_x;
    logic bor_gen;
    logic bor_prop;
    logic bor_next;

    // The half-adder pieces that the subtractor cell does not need.
    logic unused_c1;
    logic unused_c2;
    logic unused_s3;
    logic unused_s4;

    // Full-subtractor cell. The difference bit is a^b^bor, taken from two
    // chained half-adder sums. A borrow is generated when a=0 and b=1
    // (ha3 carry). An incoming borrow propagates when a==b (ha4 carry on ~x).
    assign not_a = ~sa[0];
    assign not_x = ~x;

    ha u_ha1 (.in_a(sa[0]), .in_b(sb[0]), .sum(x),         .carry(unused_c1));
    ha u_ha2 (.in_a(x),     .in_b(bor),   .sum(d),         .carry(unused_c2));
    ha u_ha3 (.in_a(not_a), .in_b(sb[0]), .sum(unused_s3), .carry(bor_gen));
    ha u_ha4 (.in_a(not_x), .in_b(bor),   .sum(unused_s4), .carry(bor_prop));

    assign bor_next = bor_gen | bor_prop;

    // Result bits enter at the MSB. After WIDTH shifts, the first
    // (LSB) bit has reached position 0.
    assign sr_next = {d, sr[WIDTH-1:1]};

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The last shift happens when cnt reaches WIDTH-1.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. Operands are captured only when idle, so a, b and start
    // changes during an operation have no effect. The visible result is
    // updated only on the final shift edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        bor <= 1'b0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= sr_next;
                    bor <= bor_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff       <= sr_next;
                        borrow_out <= bor_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_using_ha.sv
// ---------------------------------------------------------------------------
// tb_serial_sub_using_ha
//   Directed and random operations on the 8-bit serial subtractor. For each
//   operation the bench checks the result, the borrow, and the handshake
//   timing.
// ---------------------------------------------------------------------------

module tb_serial_sub_using_ha;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    int checks   = 0;
    int failures = 0;

    serial_sub_using_ha #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value, and report a
    // line if they differ.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Launch one operation and follow it to its done pulse. The start edge
    // counts as edge 1, so done is expected after edge 9 with exactly eight
    // busy cycles. After the start edge, a and b are scrambled to show that
    // the operands were captured. An optional start pulse carrying other
    // operands is injected during the shift phase.
    task automatic applyStimulus(input logic [7:0] ta, input logic [7:0] tv,
                                 input bit holdStart, input int pulseAt,
                                 input logic [7:0] expDiff, input logic expBorrow);
        int         edges;
        int         busyCycles;
        bit         seenDone;
        bit         overlap;
        bit         unstable;
        bit         pulsing;
        logic [7:0] prevDiff;
        logic       prevBor;
        edges      = 0;
        busyCycles = 0;
        seenDone   = 0;
        overlap    = 0;
        unstable   = 0;
        pulsing    = 0;
        @(negedge clk);
        a     = ta;
        b     = tv;
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        #1;
        start    = holdStart;
        a        = ~ta;
        b        = ~tv;
        prevDiff = diff;
        prevBor  = borrow_out;
        for (int i = 0; i < 30 && !seenDone; i++) begin
            @(negedge clk);
            if (pulsing) begin
                start   = holdStart;
                pulsing = 0;
            end
            if (busy && done) overlap = 1;
            if (done) begin
                seenDone = 1;
            end else begin
                if (busy) begin
                    busyCycles++;
                    if (diff !== prevDiff || borrow_out !== prevBor) unstable = 1;
                end
                if (pulseAt != 0 && busy && busyCycles == pulseAt) begin
                    start   = 1'b1;
                    a       = 8'h00;
                    b       = 8'hFF;
                    pulsing = 1;
                end
                @(posedge clk);
                edges++;
            end
        end
        checkOutput("done_seen", 32'(seenDone), 32'd1);
        checkOutput("latency_edges", 32'(edges), 32'd9);
        checkOutput("busy_cycles", 32'(busyCycles), 32'd8);
        checkOutput("busy_done_overlap", 32'(overlap), 32'd0);
        checkOutput("result_stable", 32'(unstable), 32'd0);
        checkOutput("diff", 32'(diff), 32'(expDiff));
        checkOutput("borrow_out", 32'(borrow_out), 32'(expBorrow));
    endtask

    initial begin
        bit         extra;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] wide;

        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        #3;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_diff", 32'(diff), 32'd0);
        checkOutput("reset_borrow", 32'(borrow_out), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic subtraction, no borrow
        applyStimulus(8'h5A, 8'h23, 1'b0, 0, 8'h37, 1'b0);
        // Underflow wraps around
        applyStimulus(8'h10, 8'h20, 1'b0, 0, 8'hF0, 1'b1);
        // Borrow ripples through every bit
        applyStimulus(8'h00, 8'h01, 1'b0, 0, 8'hFF, 1'b1);
        applyStimulus(8'hFF, 8'hFF, 1'b0, 0, 8'h00, 1'b0);
        // A start during the shift phase is ignored
        applyStimulus(8'h09, 8'h04, 1'b0, 3, 8'h05, 1'b0);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy || done) extra = 1;
        end
        checkOutput("no_second_op", 32'(extra), 32'd0);

        // Reset asserted after three bits have been processed
        @(negedge clk);
        a     = 8'h33;
        b     = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("busy_before_abort", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_diff", 32'(diff), 32'd0);
        checkOutput("abort_borrow", 32'(borrow_out), 32'd0);
        extra = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) extra = 1;
        end
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (done || busy) extra = 1;
        end
        checkOutput("abort_no_done", 32'(extra), 32'd0);
        applyStimulus(8'h80, 8'h01, 1'b0, 0, 8'h7F, 1'b0);

        // Back-to-back random operations, start held high
        for (int n = 0; n < 1000; n++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            wide = {1'b0, ra} - {1'b0, rb};
            applyStimulus(ra, rb, 1'b1, 0, wide[7:0], (ra < rb));
        end
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
